// File: rtl/avg_accum_seq.sv
// rtl/avg_accum_seq.sv - sample accumulator with restoring serial divider producing the run average
module avg_accum_seq #(
    parameter int DATA_W = 8,
    parameter int NUM_W  = 10,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_W-1:0]  data_num,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] avg,
    output logic              zero_err
);

    localparam int SUM_W = DATA_W + NUM_W;
    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam logic [NUM_W-1:0] ONE_N     = NUM_W'(1);
    localparam logic [CNT_W-1:0] ONE_S     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [NUM_W-1:0]  n_reg;
    logic [SUM_W-1:0]  sum;
    logic [NUM_W-1:0]  count;
    logic [SUM_W-1:0]  dvd;
    logic [NUM_W-1:0]  rem;
    logic [CNT_W-1:0]  step;
    logic              div_load;

    logic [SUM_W-1:0]  sample_ext;
    logic [SUM_W-1:0]  rnd_term;
    logic [NUM_W-1:0]  count_inc;
    logic [NUM_W:0]    trial;
    logic [NUM_W-1:0]  diff;
    logic              q_bit;
    logic [NUM_W-1:0]  rem_next;
    logic [SUM_W-1:0]  dvd_next;

    // Sample widening, rounding bias and one restoring-division step.
    // dvd shifts its dividend bits out of the top into the partial remainder
    // while quotient bits shift in at the bottom; after SUM_W steps it holds the quotient.
    always_comb begin
        sample_ext = {{NUM_W{1'b0}}, data};
        rnd_term   = '0;
        if (ROUND != 0) begin
            rnd_term = {{DATA_W{1'b0}}, 1'b0, n_reg[NUM_W-1:1]};
        end
        count_inc = count + ONE_N;
        trial     = {rem, dvd[SUM_W-1]};
        q_bit     = (trial >= {1'b0, n_reg});
        // The difference is below n_reg when q_bit is set, so NUM_W bits suffice.
        diff      = trial[NUM_W-1:0] - n_reg;
        rem_next  = q_bit ? diff : trial[NUM_W-1:0];
        dvd_next  = {dvd[SUM_W-2:0], q_bit};
    end

    // Run sequencer: capture, accumulate, divide, report; outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_reg    <= '0;
            sum      <= '0;
            count    <= '0;
            dvd      <= '0;
            rem      <= '0;
            step     <= '0;
            div_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            zero_err <= 1'b0;
            avg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg <= data_num;
                        sum   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        if (data_num == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            zero_err <= 1'b1;
                            avg      <= '0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (data_valid) begin
                        sum   <= sum + sample_ext;
                        count <= count_inc;
                        if (count_inc == n_reg) begin
                            state    <= DIVIDE;
                            div_load <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    // First DIVIDE cycle loads the dividend; SUM_W quotient steps follow.
                    if (div_load) begin
                        dvd      <= sum + rnd_term;
                        rem      <= '0;
                        step     <= '0;
                        div_load <= 1'b0;
                    end else begin
                        dvd  <= dvd_next;
                        rem  <= rem_next;
                        step <= step + ONE_S;
                        if (step == LAST_STEP) begin
                            state <= DONE;
                            done  <= 1'b1;
                            avg   <= dvd_next[DATA_W-1:0];
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    zero_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avg_accum_seq.sv
// tb/tb_avg_accum_seq.sv - directed self-checking bench for avg_accum_seq, truncating and rounding instances
module tb_avg_accum_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] data_num;
    logic       data_valid;
    logic [7:0] data;

    logic       busy0, done0, zerr0;
    logic [7:0] avg0;
    logic       busy1, done1, zerr1;
    logic [7:0] avg1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avg_accum_seq #(.DATA_W(8), .NUM_W(10), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_num(data_num),
        .data_valid(data_valid), .data(data),
        .busy(busy0), .done(done0), .avg(avg0), .zero_err(zerr0)
    );

    avg_accum_seq #(.DATA_W(8), .NUM_W(10), .ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_num(data_num),
        .data_valid(data_valid), .data(data),
        .busy(busy1), .done(done1), .avg(avg1), .zero_err(zerr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [9:0] n);
        @(negedge clk);
        start    = 1'b1;
        data_num = n;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int gap, input logic poke);
        for (int i = 0; i < gap; i++) begin
            start      = poke;
            data_valid = 1'b0;
            @(negedge clk);
        end
        start      = 1'b0;
        data_valid = 1'b1;
        data       = d;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Called at the negedge after the last-sample edge; counts edges until done.
    task automatic finish_run(input string tag, input int poke_at,
                              input logic [7:0] exp0, input logic [7:0] exp1);
        int lat;
        lat = 0;
        while (!done0 && lat < 100) begin
            start = (poke_at != 0 && lat + 1 == poke_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, lat, 19);
        check({tag, " done1"}, done1, 1);
        check({tag, " avg trunc"}, avg0, exp0);
        check({tag, " avg round"}, avg1, exp1);
        check({tag, " zero_err"}, {zerr0, zerr1}, 0);
        @(negedge clk);
        check({tag, " done pulse"}, {done0, done1}, 0);
        check({tag, " idle"}, {busy0, busy1}, 0);
        check({tag, " avg held"}, avg0, exp0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        data_num   = '0;
        data_valid = 1'b0;
        data       = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy0, done0, zerr0, busy1, done1, zerr1}, 0);
        check("reset avg", {avg0, avg1}, 0);
        rst_n = 1'b1;

        // 10,20,30,42 -> sum 102: trunc 25, round (102+2)/4 = 26
        start_run(10'd4);
        check("run1 busy", {busy0, busy1}, 2'b11);
        send(8'd10, 0, 1'b0);
        send(8'd20, 0, 1'b0);
        send(8'd30, 0, 1'b0);
        send(8'd42, 0, 1'b0);
        finish_run("run1", 0, 8'd25, 8'd26);

        // 1,1,1,2 -> sum 5: trunc 1, round 7/4 = 1
        start_run(10'd4);
        send(8'd1, 0, 1'b0);
        send(8'd1, 0, 1'b0);
        send(8'd1, 0, 1'b0);
        send(8'd2, 0, 1'b0);
        finish_run("run2", 0, 8'd1, 8'd1);

        // 1023 x 255 -> 255 in both modes, sum must not wrap
        start_run(10'd1023);
        for (int i = 0; i < 1022; i++) begin
            data_valid = 1'b1;
            data       = 8'd255;
            @(negedge clk);
        end
        send(8'd255, 0, 1'b0);
        finish_run("full", 0, 8'd255, 8'd255);

        // 9,0,6 with gaps and stray starts -> 15/3 = 5, (15+1)/3 = 5
        start_run(10'd3);
        send(8'd9, 0, 1'b0);
        send(8'd0, 2, 1'b1);
        send(8'd6, 2, 1'b1);
        finish_run("gaps", 5, 8'd5, 8'd5);
        check("gaps count", dut0.count, 3);

        // zero run: done + zero_err right after the start edge
        start_run(10'd0);
        check("zero done", {done0, done1}, 2'b11);
        check("zero err", {zerr0, zerr1}, 2'b11);
        check("zero avg", {avg0, avg1}, 0);
        check("zero busy", {busy0, busy1}, 2'b11);
        @(negedge clk);
        check("zero after", {busy0, done0, zerr0, busy1, done1, zerr1}, 0);

        // reset in the 5th DIVIDE cycle aborts the run
        start_run(10'd2);
        send(8'd3, 0, 1'b0);
        send(8'd200, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("abort in divide", dut0.state, 2);
        rst_n = 1'b0;
        #1;
        check("abort outputs", {busy0, done0, zerr0, busy1, done1, zerr1}, 0);
        check("abort avg", {avg0, avg1}, 0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done0 || done1) check("abort no done", {done0, done1}, 0);
        end
        rst_n = 1'b1;

        // 7,8 after reset: trunc 7, round (15+1)/2 = 8
        start_run(10'd2);
        send(8'd7, 0, 1'b0);
        send(8'd8, 0, 1'b0);
        finish_run("post reset", 0, 8'd7, 8'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avg_accum_seq.md
AVG_ACCUM_SEQ -- requirements
Module: avg_accum_seq

Interface
REQ-001 Parameter DATA_W, default 8: sample and average width, in bits.
REQ-002 Parameter NUM_W, default 10: sample-count width; SUM_W is fixed at DATA_W+NUM_W.
REQ-003 Parameter ROUND, default 0: 0 truncates the quotient; 1 rounds half-up.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a new averaging run; sampled only in IDLE.
REQ-007 data_num  input  NUM_W  number of samples in the run; captured on the accepted start.
REQ-008 data_valid  input  1  data qualifies as a sample this cycle.
REQ-009 data  input  DATA_W  unsigned sample.
REQ-010 busy  output  1  high in ACCUM, DIVIDE and DONE states.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 avg  output  DATA_W  unsigned average; holds its value until the next done.
REQ-013 zero_err  output  1  one-cycle pulse together with done when captured data_num was 0.

Function
REQ-014 The FSM SHALL have the states IDLE, ACCUM, DIVIDE and DONE, encoded in one state register.
REQ-015 IDLE: start=1 SHALL capture data_num into n_reg, clear sum and count, and go to ACCUM (or to DONE with zero_err if data_num=0).
REQ-016 start asserted outside IDLE SHALL be ignored, with no restart and no queuing.
REQ-017 data_valid outside ACCUM SHALL be ignored.
REQ-018 ACCUM: each cycle with data_valid=1 SHALL add zero-extended data to the SUM_W-bit sum and increment count; cycles with data_valid=0 stall with no change.
REQ-019 ACCUM SHALL exit to DIVIDE on the edge that accepts sample number n_reg.
REQ-020 On DIVIDE entry, the dividend SHALL be sum, or sum+(n_reg>>1) if ROUND=1; the divisor is n_reg.
REQ-021 DIVIDE SHALL be a restoring divider: one quotient bit per cycle, MSB first, for exactly SUM_W cycles, then DONE.
REQ-022 The divider SHALL NOT use the / operator and SHALL NOT use a combinational divider.
REQ-023 Width rule: the quotient is always at most 2^DATA_W-1, so avg SHALL be the low DATA_W quotient bits, with no saturation needed.
REQ-024 DONE lasts one cycle: done=1, avg updated on DONE entry, then IDLE.
REQ-025 In the DONE state for a zero run, avg SHALL be forced to 0 and zero_err=1.
REQ-026 Latency: done SHALL be high in the cycle SUM_W+1 edges after the edge accepting the last sample (18+1=19 at defaults).
REQ-027 Latency, zero run: done SHALL be high in the cycle right after the start edge.
REQ-028 A new start SHALL be accepted in IDLE on the cycle after done, giving one dead cycle between runs.
REQ-029 The sum SHALL never wrap for data_num ≤ 2^NUM_W-1, with or without the rounding term.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE, busy=0, done=0 and zero_err=0.
REQ-031 While rst_n=0, avg, sum, count, n_reg and all divider registers SHALL be 0.
REQ-032 Reset asserted mid-run in any state SHALL abort the run immediately with no done pulse.
REQ-033 The first run after reset release SHALL behave identically to a run from power-up.

Verification
REQ-034 ROUND=0, data_num=4, samples 10,20,30,42 back-to-back -> avg=25, done 19 cycles after the 4th sample, zero_err=0.
REQ-035 ROUND=1, same stimulus -> avg=26; also samples 1,1,1,2 -> avg=1 (5+2=7, 7/4=1).
REQ-036 data_num=1023, all samples 255, ROUND=0 and ROUND=1 -> avg=255 in both cases, with no overflow of sum.
REQ-037 data_num=3, samples 9,0,6 with 2-cycle data_valid gaps, plus start pulsed during ACCUM and DIVIDE -> avg=5, run not restarted, count=3.
REQ-038 data_num=0 -> done and zero_err pulse together 1 cycle after start, avg=0, busy high for 1 cycle.
REQ-039 rst_n pulsed low in the 5th DIVIDE cycle -> no done pulse, all outputs 0; the next run (2 samples 7,8, ROUND=0) -> avg=7.
